arbitro_alu: RTL

ARBITRO_ALU -- requirements
Module: arbitro_alu

---
 rtl/arbitro_alu_if.sv | 37 +++
 rtl/arbitro_alu.sv | 124 ++++++++++++
 2 files changed

// File: rtl/arbitro_alu_if.sv
// Request/ALU/response bundle between requesters, the arbiter and the external ALU.
// master = environment (requesters, ALU, consumer); slave = arbitro_alu.
interface arbitro_alu_if #(parameter int N_BITS = 8);
  logic              sol0_valido;
  logic              sol1_valido;
  logic [N_BITS-1:0] sol0_a;
  logic [N_BITS-1:0] sol0_b;
  logic [N_BITS-1:0] sol1_a;
  logic [N_BITS-1:0] sol1_b;
  logic [2:0]        sol0_op;
  logic [2:0]        sol1_op;
  logic              sol0_listo;
  logic              sol1_listo;
  logic [N_BITS-1:0] alu_a;
  logic [N_BITS-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [N_BITS-1:0] alu_resultado;
  logic              resp_valido;
  logic              resp_id;
  logic [N_BITS-1:0] resp_resultado;
  logic              resp_error;
  logic              resp_listo;

  modport master (
    output sol0_valido, sol1_valido, sol0_a, sol0_b, sol1_a, sol1_b, sol0_op, sol1_op,
    output alu_resultado, resp_listo,
    input  sol0_listo, sol1_listo, alu_a, alu_b, alu_op,
    input  resp_valido, resp_id, resp_resultado, resp_error
  );

  modport slave (
    input  sol0_valido, sol1_valido, sol0_a, sol0_b, sol1_a, sol1_b, sol0_op, sol1_op,
    input  alu_resultado, resp_listo,
    output sol0_listo, sol1_listo, alu_a, alu_b, alu_op,
    output resp_valido, resp_id, resp_resultado, resp_error
  );
endinterface

// File: rtl/arbitro_alu.sv
// Two-requester arbiter in front of a combinational ALU; ARBITRO_ALU_ROUND_ROBIN_EN selects round-robin over fixed priority.
// Latency: accept edge -> resp_valido after the second edge; one op in flight, next accept 3 cycles later at best.
// Backpressure: response held in ENTREGA until resp_listo; no listo is raised outside ESPERA.
module arbitro_alu #(
  parameter int N_BITS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  arbitro_alu_if.slave  bus
);

  typedef enum logic [1:0] {ESPERA, EJECUTA, ENTREGA} state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              id_q, id_d;
  logic              resp_valido_q, resp_valido_d;
  logic              resp_id_q, resp_id_d;
  logic              resp_error_q, resp_error_d;
  logic [N_BITS-1:0] resp_resultado_q, resp_resultado_d;

  logic gnt0, gnt1, accept, op_ok;

`ifdef ARBITRO_ALU_ROUND_ROBIN_EN
  // last_q holds the id served last; reset to 1 so requester 0 wins first.
  logic last_q, last_d;

  always_comb begin
    gnt0   = bus.sol0_valido & (~bus.sol1_valido | last_q);
    gnt1   = bus.sol1_valido & (~bus.sol0_valido | ~last_q);
    last_d = accept ? gnt1 : last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  always_comb begin
    gnt0 = bus.sol0_valido;
    gnt1 = bus.sol1_valido & ~bus.sol0_valido;
  end
`endif

  assign accept = (state_q == ESPERA) & (gnt0 | gnt1);
  assign op_ok  = (op_q >= 3'd1) && (op_q <= 3'd4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ESPERA;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ESPERA:  if (accept)         state_d = EJECUTA;
      EJECUTA:                     state_d = ENTREGA;
      ENTREGA: if (bus.resp_listo) state_d = ESPERA;
      default:                     state_d = ESPERA;
    endcase
  end

  always_comb begin
    bus.sol0_listo     = (state_q == ESPERA) & gnt0;
    bus.sol1_listo     = (state_q == ESPERA) & gnt1;
    bus.alu_a          = a_q;
    bus.alu_b          = b_q;
    bus.alu_op         = (state_q == EJECUTA) ? op_q : 3'b000;
    bus.resp_valido    = resp_valido_q;
    bus.resp_id        = resp_id_q;
    bus.resp_error     = resp_error_q;
    bus.resp_resultado = resp_resultado_q;
  end

  // Datapath registers: operands captured on accept, response captured leaving EJECUTA.
  always_comb begin
    a_d              = a_q;
    b_d              = b_q;
    op_d             = op_q;
    id_d             = id_q;
    resp_valido_d    = resp_valido_q;
    resp_id_d        = resp_id_q;
    resp_error_d     = resp_error_q;
    resp_resultado_d = resp_resultado_q;
    if (accept) begin
      a_d  = gnt1 ? bus.sol1_a  : bus.sol0_a;
      b_d  = gnt1 ? bus.sol1_b  : bus.sol0_b;
      op_d = gnt1 ? bus.sol1_op : bus.sol0_op;
      id_d = gnt1;
    end
    if (state_q == EJECUTA) begin
      resp_valido_d    = 1'b1;
      resp_id_d        = id_q;
      resp_error_d     = ~op_ok;
      resp_resultado_d = op_ok ? bus.alu_resultado : '0;
    end
    if ((state_q == ENTREGA) && bus.resp_listo) resp_valido_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q              <= '0;
      b_q              <= '0;
      op_q             <= '0;
      id_q             <= 1'b0;
      resp_valido_q    <= 1'b0;
      resp_id_q        <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_resultado_q <= '0;
    end else begin
      a_q              <= a_d;
      b_q              <= b_d;
      op_q             <= op_d;
      id_q             <= id_d;
      resp_valido_q    <= resp_valido_d;
      resp_id_q        <= resp_id_d;
      resp_error_q     <= resp_error_d;
      resp_resultado_q <= resp_resultado_d;
    end
  end

endmodule
